mc_controller: RTL

Multi-cycle control sequencer for the MIPS core datapath. It replaces the single-cycle combinational controller once the datapath is split by IR, A/B, ALUOut and MDR registers. It decodes the latched instruction and steps the datapath through fetch, decode, execute, memory and writeback. It waits on ready handshakes from instruction and data memory, and drives every write enable and mux select each cycle.

---
 rtl/mc_pkg.sv | 84 ++++++++
 rtl/mc_decode.sv | 35 +++
 rtl/mc_controller.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, select codes,
// ALU operations, opcode/funct constants and the decoded instruction class.
package mc_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALU_OP_W = 3;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_WB_ALU = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_MEM = 4'd7,
        S_MEM_WR = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_JR     = 4'd11
    } state_e;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_OR  = 3'b010,
        ALU_LUI = 3'b011,
        ALU_SLL = 3'b100
    } alu_op_e;

    typedef enum logic [SEL_W-1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_REG    = 2'b11
    } pc_src_e;

    typedef enum logic [SEL_W-1:0] {
        DST_RD = 2'b00,
        DST_RT = 2'b01,
        DST_RA = 2'b10
    } reg_dst_e;

    typedef enum logic [SEL_W-1:0] {
        SRC_ALU = 2'b00,
        SRC_MDR = 2'b01,
        SRC_PC4 = 2'b10
    } reg_src_e;

    typedef enum logic [3:0] {
        CLS_R_ALU   = 4'd0,
        CLS_I_ALU   = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JUMP    = 4'd5,
        CLS_JAL     = 4'd6,
        CLS_JR      = 4'd7,
        CLS_INVALID = 4'd8
    } iclass_e;

    typedef struct packed {
        iclass_e cls;
        alu_op_e alu;
    } decode_t;

    localparam logic [OP_W-1:0] OP_SPECIAL = 6'b000000;
    localparam logic [OP_W-1:0] OP_ORI     = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI     = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW      = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW      = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ     = 6'b000100;
    localparam logic [OP_W-1:0] OP_J       = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL     = 6'b000011;

    localparam logic [FUNCT_W-1:0] F_ADDU = 6'b100001;
    localparam logic [FUNCT_W-1:0] F_SUBU = 6'b100011;
    localparam logic [FUNCT_W-1:0] F_SLL  = 6'b000000;
    localparam logic [FUNCT_W-1:0] F_JR   = 6'b001000;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/funct decoder: instruction class plus the ALU operation
// that the execute-type states apply for that instruction.
import mc_pkg::*;

module mc_decode (
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    output decode_t            dec
);

    always_comb begin
        dec.cls = CLS_INVALID;
        dec.alu = ALU_ADD;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    F_ADDU: begin dec.cls = CLS_R_ALU; dec.alu = ALU_ADD; end
                    F_SUBU: begin dec.cls = CLS_R_ALU; dec.alu = ALU_SUB; end
                    F_SLL:  begin dec.cls = CLS_R_ALU; dec.alu = ALU_SLL; end
                    F_JR:   dec.cls = CLS_JR;
                    default: ;
                endcase
            end
            OP_ORI: begin dec.cls = CLS_I_ALU;  dec.alu = ALU_OR;  end
            OP_LUI: begin dec.cls = CLS_I_ALU;  dec.alu = ALU_LUI; end
            OP_LW:  dec.cls = CLS_LOAD;
            OP_SW:  dec.cls = CLS_STORE;
            OP_BEQ: begin dec.cls = CLS_BRANCH; dec.alu = ALU_SUB; end
            OP_J:   dec.cls = CLS_JUMP;
            OP_JAL: dec.cls = CLS_JAL;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control sequencer: steps the split datapath through
// fetch/decode/execute/memory/writeback, waiting on memory ready handshakes.
import mc_pkg::*;

module mc_controller (
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     op,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                equal,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                pc_write,
    output logic [SEL_W-1:0]    pc_src,
    output logic                ir_write,
    output logic                reg_write,
    output logic [SEL_W-1:0]    reg_dst,
    output logic [SEL_W-1:0]    reg_src,
    output logic                alu_src_b,
    output logic                sign_ext,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                mem_read,
    output logic                mem_write,
    output logic                instr_done,
    output logic [STATE_W-1:0]  state
);

    state_e  state_q;
    state_e  state_next;
    decode_t dec;

    mc_decode u_decode (
        .op    (op),
        .funct (funct),
        .dec   (dec)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_next;
    end

    assign state = state_q;

    // Next-state and Moore-plus-live-input output decode
    always_comb begin
        state_next = state_q;
        pc_write   = 1'b0;
        pc_src     = PC_PLUS4;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = DST_RD;
        reg_src    = SRC_ALU;
        alu_src_b  = 1'b0;
        sign_ext   = 1'b0;
        alu_op     = ALU_ADD;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_write = imem_ready;
                pc_write = imem_ready;
                if (imem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                case (dec.cls)
                    CLS_R_ALU:              state_next = S_EXEC_R;
                    CLS_I_ALU:              state_next = S_EXEC_I;
                    CLS_LOAD, CLS_STORE:    state_next = S_ADDR;
                    CLS_BRANCH:             state_next = S_BRANCH;
                    CLS_JUMP, CLS_JAL:      state_next = S_JUMP;
                    CLS_JR:                 state_next = S_JR;
                    default: begin
                        instr_done = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_op     = dec.alu;
                state_next = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_op     = dec.alu;
                alu_src_b  = 1'b1;
                state_next = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                reg_dst    = (dec.cls == CLS_I_ALU) ? DST_RT : DST_RD;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDR: begin
                alu_src_b  = 1'b1;
                sign_ext   = 1'b1;
                state_next = (dec.cls == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                if (dmem_ready) state_next = S_WB_MEM;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                reg_dst    = DST_RT;
                reg_src    = SRC_MDR;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                instr_done = dmem_ready;
                if (dmem_ready) state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_op     = ALU_SUB;
                pc_src     = PC_BRANCH;
                pc_write   = equal;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = PC_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                if (dec.cls == CLS_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = DST_RA;
                    reg_src   = SRC_PC4;
                end
                state_next = S_FETCH;
            end
            S_JR: begin
                pc_src     = PC_REG;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase

        // Reset cycles must not disturb architectural state even mid-instruction
        if (reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule
